// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: fetch PC, single outstanding ibus request, IF/ID register
module if_fetch_unit #(
   parameter logic [63:0] PC_INIT = 64'h0000_0000_8000_0000
) (
   input  logic         clk,
   input  logic         reset,
   output logic [64:0]  ireq,
   input  logic [33:0]  iresp,
   input  logic         stall,
   input  logic         redirect_valid,
   input  logic [63:0]  redirect_pc,
   output logic [224:0] if_id
);

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      DISCARD = 2'd1,
      HOLD    = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [63:0] pc;
   logic [63:0] pend_pc;
   logic        data_ok;
   logic [31:0] instr;
   logic [63:0] redir_aligned;
   logic [63:0] pc_plus4;
   logic        req_valid;
   logic        unused_bits;

   assign data_ok       = iresp[32];
   assign instr         = iresp[31:0];
   assign redir_aligned = {redirect_pc[63:2], 2'b00};
   assign pc_plus4      = pc + 64'd4;
   assign unused_bits   = ^{iresp[33], redirect_pc[1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         FETCH: begin
            if (data_ok && !redirect_valid) begin
               state_next = HOLD;
            end else if (!data_ok && redirect_valid) begin
               state_next = DISCARD;
            end
         end
         DISCARD: begin
            if (data_ok) begin
               state_next = FETCH;
            end
         end
         HOLD: begin
            if (redirect_valid || !stall) begin
               state_next = FETCH;
            end
         end
         default: state_next = FETCH;
      endcase
   end

   always_comb begin
      req_valid = (state != HOLD);
      ireq      = {req_valid, pc};
   end

   // The request address only moves when the outstanding request completes, or from HOLD.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= PC_INIT;
         pend_pc <= '0;
         if_id   <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (data_ok && !redirect_valid) begin
                  if_id <= {1'b1, pc_plus4, pc, instr, pc};
               end else if (data_ok) begin
                  pc <= redir_aligned;
               end else if (redirect_valid) begin
                  pend_pc <= redir_aligned;
               end
            end
            DISCARD: begin
               if (redirect_valid) begin
                  pend_pc <= redir_aligned;
               end
               if (data_ok) begin
                  pc <= redirect_valid ? redir_aligned : pend_pc;
               end
            end
            HOLD: begin
               if (redirect_valid) begin
                  if_id[224] <= 1'b0;
                  pc         <= redir_aligned;
               end else if (!stall) begin
                  if_id[224] <= 1'b0;
                  pc         <= pc_plus4;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;

   localparam logic [63:0] PC_INIT = 64'h0000_0000_8000_0000;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         stall = 1'b0;
   logic         redirect_valid = 1'b0;
   logic [63:0]  redirect_pc = '0;
   logic         man_ok = 1'b0;
   logic [64:0]  ireq;
   logic [33:0]  iresp;
   logic [224:0] if_id;

   int n_checks = 0;
   int n_pass = 0;

   logic [64:0]  exp_req_q[$];
   logic [224:0] exp_ifid_q[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return 32'h0000_0013 ^ (a[31:0] - 32'h8000_0000);
   endfunction

   function automatic logic [224:0] mk_ifid(input logic [63:0] a);
      logic [63:0] p4;
      p4 = a + 64'd4;
      return {1'b1, p4, a, instr_of(a), a};
   endfunction

   function automatic logic [64:0] mk_req(input logic [63:0] a);
      return {1'b1, a};
   endfunction

   // Cache model: data is a function of the requested address, completion is driven by the test.
   assign iresp = {ireq[64], man_ok, instr_of(ireq[63:0])};

   if_fetch_unit #(.PC_INIT(PC_INIT)) dut (
      .clk            (clk),
      .reset          (reset),
      .ireq           (ireq),
      .iresp          (iresp),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_id          (if_id)
   );

   task automatic check(input string tag, input logic [224:0] obs, input logic [224:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [63:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
   endtask

   logic        prev_valid = 1'b0;
   logic        prev_ok = 1'b0;
   logic        prev_ifv = 1'b0;
   logic [64:0] prev_ireq = '0;

   always @(negedge clk) begin
      if (reset) begin
         prev_valid = 1'b0;
         prev_ok    = 1'b0;
         prev_ifv   = 1'b0;
      end else begin
         if (prev_valid && !prev_ok) begin
            check("bus_hold", ireq, prev_ireq);
         end
         if (ireq[64] && (!prev_valid || prev_ok)) begin
            if (exp_req_q.size() == 0) check("req_extra", ireq, '0);
            else check("req_addr", ireq, exp_req_q.pop_front());
         end
         if (if_id[224] && !prev_ifv) begin
            if (exp_ifid_q.size() == 0) check("ifid_extra", if_id, '0);
            else check("ifid_data", if_id, exp_ifid_q.pop_front());
         end
         prev_valid = ireq[64];
         prev_ok    = ireq[64] & man_ok;
         prev_ifv   = if_id[224];
         prev_ireq  = ireq;
      end
   end

   initial begin
      step();
      step();
      check("rst_ireq", ireq, mk_req(PC_INIT));
      check("rst_ifid", if_id, '0);

      // Same-cycle response, then consumption.
      exp_req_q.push_back(mk_req(PC_INIT));
      exp_ifid_q.push_back(mk_ifid(PC_INIT));
      exp_req_q.push_back(mk_req(PC_INIT + 64'd4));
      reset  = 1'b0;
      man_ok = 1'b1;
      step();
      man_ok = 1'b0;
      check("t1_ifid", if_id, mk_ifid(PC_INIT));
      check("t1_hold_noreq", ireq[64], 1'b0);
      step();
      check("t1_next_req", ireq, mk_req(PC_INIT + 64'd4));
      check("t1_ifid_drop", if_id[224], 1'b0);

      // Stall held in HOLD.
      exp_ifid_q.push_back(mk_ifid(PC_INIT + 64'd4));
      man_ok = 1'b1;
      stall  = 1'b1;
      step();
      man_ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t2_ifid_held", if_id, mk_ifid(PC_INIT + 64'd4));
         check("t2_noreq", ireq[64], 1'b0);
         step();
      end
      exp_req_q.push_back(mk_req(PC_INIT + 64'd8));
      stall = 1'b0;
      step();
      check("t2_ifid_drop", if_id[224], 1'b0);
      check("t2_next_req", ireq, mk_req(PC_INIT + 64'd8));

      // Delayed response with a misaligned redirect in cycle 1.
      step();
      redirect(64'h0000_0000_8000_1002);
      step();
      redirect_valid = 1'b0;
      check("t3_addr_held", ireq, mk_req(PC_INIT + 64'd8));
      step();
      check("t3_addr_held2", ireq, mk_req(PC_INIT + 64'd8));
      man_ok = 1'b1;
      exp_req_q.push_back(mk_req(64'h0000_0000_8000_1000));
      step();
      man_ok = 1'b0;
      check("t3_redir_req", ireq, mk_req(64'h0000_0000_8000_1000));
      check("t3_dropped", if_id[224], 1'b0);

      // Several redirects during DISCARD; the one coinciding with data_ok wins.
      redirect(64'h0000_0000_8000_2000);
      step();
      redirect(64'h9000);
      step();
      redirect(64'hA000);
      step();
      redirect(64'hB000);
      man_ok = 1'b1;
      exp_req_q.push_back(mk_req(64'hB000));
      step();
      redirect_valid = 1'b0;
      man_ok = 1'b0;
      check("t4_last_redir", ireq, mk_req(64'hB000));

      // Pending target used when data_ok arrives without a redirect.
      redirect(64'hC000);
      step();
      redirect(64'hD006);
      step();
      redirect_valid = 1'b0;
      man_ok = 1'b1;
      exp_req_q.push_back(mk_req(64'hD004));
      step();
      man_ok = 1'b0;
      check("t4_pend_pc", ireq, mk_req(64'hD004));

      // data_ok and redirect together in FETCH.
      man_ok = 1'b1;
      redirect(64'hE000);
      exp_req_q.push_back(mk_req(64'hE000));
      step();
      man_ok = 1'b0;
      redirect_valid = 1'b0;
      check("t4c_req", ireq, mk_req(64'hE000));
      check("t4c_no_ifid", if_id[224], 1'b0);

      // Redirect and stall together in HOLD.
      man_ok = 1'b1;
      stall  = 1'b1;
      exp_ifid_q.push_back(mk_ifid(64'hE000));
      step();
      man_ok = 1'b0;
      redirect(64'hF000);
      exp_req_q.push_back(mk_req(64'hF000));
      step();
      redirect_valid = 1'b0;
      stall = 1'b0;
      check("t5_ifid_drop", if_id[224], 1'b0);
      check("t5_req", ireq, mk_req(64'hF000));

      // Wrap of pc+4.
      man_ok = 1'b1;
      redirect(64'hFFFF_FFFF_FFFF_FFFC);
      exp_req_q.push_back(mk_req(64'hFFFF_FFFF_FFFF_FFFC));
      step();
      redirect_valid = 1'b0;
      exp_ifid_q.push_back(mk_ifid(64'hFFFF_FFFF_FFFF_FFFC));
      exp_req_q.push_back(mk_req(64'h0));
      step();
      man_ok = 1'b0;
      check("t6_pcplus4", if_id[223:160], 64'h0);
      step();
      check("t6_wrap_req", ireq, mk_req(64'h0));

      // Reset while in DISCARD.
      redirect(64'h1234);
      step();
      redirect_valid = 1'b0;
      check("t7_discard_addr", ireq, mk_req(64'h0));
      reset = 1'b1;
      step();
      check("t7_rst_ireq", ireq, mk_req(PC_INIT));
      check("t7_rst_ifid", if_id, '0);

      // Reset while in HOLD clears the IF/ID register.
      exp_req_q.push_back(mk_req(PC_INIT));
      exp_ifid_q.push_back(mk_ifid(PC_INIT));
      reset  = 1'b0;
      man_ok = 1'b1;
      step();
      man_ok = 1'b0;
      stall  = 1'b1;
      step();
      check("t8_hold", if_id, mk_ifid(PC_INIT));
      reset = 1'b1;
      step();
      check("t8_rst_ifid", if_id, '0);
      check("t8_rst_ireq", ireq, mk_req(PC_INIT));
      exp_req_q.push_back(mk_req(PC_INIT));
      reset = 1'b0;
      stall = 1'b0;
      step();
      step();
      check("sb_req_drain", exp_req_q.size(), 0);
      check("sb_ifid_drain", exp_ifid_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
